// File: rtl/line_window_buffer_if.sv
// Pixel-in / window-out bundle for line_window_buffer. The master side drives the
// pixel stream and frame/line markers; the slave side returns the row window.
interface line_window_buffer_if #(
  parameter int LINE_WIDTH = 320,
  parameter int PIX_W      = 1,
  parameter int WIN_ROWS   = 5
);
  logic                                en;
  logic                                frame_start;
  logic                                line_start;
  logic                                pix_valid;
  logic [PIX_W-1:0]                    pix_in;
  logic [WIN_ROWS*LINE_WIDTH*PIX_W-1:0] win_rows;
  logic                                row_update;
  logic                                window_valid;
  logic [8:0]                          row_idx;
  logic                                line_err;

  modport master (
    output en, frame_start, line_start, pix_valid, pix_in,
    input  win_rows, row_update, window_valid, row_idx, line_err
  );

  modport slave (
    input  en, frame_start, line_start, pix_valid, pix_in,
    output win_rows, row_update, window_valid, row_idx, line_err
  );
endinterface

// File: rtl/line_window_buffer.sv
// Packs a serial pixel stream into lines and keeps the last WIN_ROWS lines as a window.
// Optional macro BORDER_ZERO_EN zeroes BORDER edge columns on each side of a committed row.
module lwb_row_reg #(
  parameter int W = 320
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q_o <= '0;
    else if (ld_i) q_o <= d_i;
  end
endmodule

module line_window_buffer #(
  parameter int LINE_WIDTH = 320,
  parameter int PIX_W      = 1,
  parameter int WIN_ROWS   = 5,
  parameter int BORDER     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  line_window_buffer_if.slave      bus
);
  localparam int ROW_W = LINE_WIDTH * PIX_W;
  localparam int CW    = $clog2(LINE_WIDTH);

  typedef logic [LINE_WIDTH-1:0][PIX_W-1:0] line_t;

  logic [CW-1:0] col_q, col_d, col_eff;
  logic          ovf_q, ovf_d;
  line_t         asm_q, asm_d, line_new;
  logic [8:0]    idx_q, idx_d;
  logic          wv_q, wv_d;
  logic          err_q, err_d;
  logic          upd_q, upd_d;
  logic          commit;

  logic [WIN_ROWS-1:0][ROW_W-1:0] win_q, win_in;

  always_comb begin
    col_d    = col_q;
    col_eff  = col_q;
    ovf_d    = ovf_q;
    asm_d    = asm_q;
    idx_d    = idx_q;
    wv_d     = wv_q;
    err_d    = err_q;
    upd_d    = 1'b0;
    commit   = 1'b0;
    if (bus.en) begin
      if (bus.frame_start) begin
        col_eff = '0;
        ovf_d   = 1'b0;
        idx_d   = '0;
        wv_d    = 1'b0;
        err_d   = 1'b0;
      end else if (bus.line_start) begin
        // Only a partial line counts as short; the idle gap after a commit does not.
        if (col_q != '0 && !ovf_q) err_d = 1'b1;
        col_eff = '0;
        ovf_d   = 1'b0;
      end
      col_d = col_eff;
      if (bus.pix_valid && !ovf_d) begin
        asm_d[col_eff] = bus.pix_in;
        if (col_eff == CW'(LINE_WIDTH-1)) begin
          commit = 1'b1;
          col_d  = '0;
          ovf_d  = 1'b1;
          upd_d  = 1'b1;
          if (idx_q != 9'h1FF) idx_d = idx_q + 9'd1;
          wv_d   = (idx_d >= 9'(WIN_ROWS));
        end else begin
          col_d = col_eff + 1'b1;
        end
      end
    end
  end

  always_comb begin
    line_new = asm_d;
`ifdef BORDER_ZERO_EN
    for (int c = 0; c < BORDER; c++) begin
      line_new[c]              = '0;
      line_new[LINE_WIDTH-1-c] = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      ovf_q <= 1'b0;
      asm_q <= '0;
      idx_q <= '0;
      wv_q  <= 1'b0;
      err_q <= 1'b0;
      upd_q <= 1'b0;
    end else begin
      col_q <= col_d;
      ovf_q <= ovf_d;
      asm_q <= asm_d;
      idx_q <= idx_d;
      wv_q  <= wv_d;
      err_q <= err_d;
      upd_q <= upd_d;
    end
  end

  // Window rows shift together on commit; row 0 takes the freshly assembled line.
  for (genvar k = 0; k < WIN_ROWS; k++) begin : g_row
    if (k == 0) begin : g_head
      assign win_in[k] = ROW_W'(line_new);
    end else begin : g_tail
      assign win_in[k] = win_q[k-1];
    end
    lwb_row_reg #(.W(ROW_W)) u_row (
      .clk   (clk),
      .rst_n (rst_n),
      .ld_i  (commit),
      .d_i   (win_in[k]),
      .q_o   (win_q[k])
    );
  end

  assign bus.win_rows     = win_q;
  assign bus.row_update   = upd_q;
  assign bus.window_valid = wv_q;
  assign bus.row_idx      = idx_q;
  assign bus.line_err     = err_q;
endmodule
